// File: rtl/soc_bus_master.sv
// soc_bus_master
//   Single-outstanding command-to-bus bridge. A command (read or write) is
//   accepted in IDLE and turned into a one-cycle strobe on the risc_v_* bus.
//   Read data is captured READ_LATENCY cycles after the strobe. A response is
//   then held until it is consumed. Alongside the bridge runs a small sticky
//   spike-flag accumulator that does not depend on the transaction FSM.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | cmd_ready high, waiting for cmd_valid
//   ISSUE | one-cycle read or write strobe on the bus
//   WAIT  | read in flight, counting down to the data-valid cycle
//   RESP  | response held on rsp_* until rsp_ready
//
// Parameters
//   READ_LATENCY    cycles from the read strobe to valid bus read data (1..7)
//
// Ports
//   clk, reset         clock, synchronous active-high reset
//   cmd_valid/ready    command handshake
//   cmd_write          1 = write, 0 = read
//   cmd_addr           10-bit register address
//   cmd_wdata          32-bit write data
//   rsp_valid/ready    response handshake
//   rsp_write          echo of the command type
//   rsp_rdata          read data (0 for writes)
//   risc_v_read        one-cycle read strobe
//   risc_v_write       one-cycle write strobe
//   risc_v_addr        bus address (holds between transactions)
//   risc_v_data_in     bus write data (holds between transactions)
//   risc_v_data_out    bus read data
//   spike_detected     per-channel spike flags
//   spike_clr          clear accumulated spike flags
//   spike_sticky       accumulated spike flags
//   spike_event        one-cycle pulse when a new spike bit appears
//   txn_count          completed transactions, wraps at 16 bits

module soc_bus_master #(
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [9:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_write,
  output logic [15:0] rsp_rdata,
  output logic        risc_v_read,
  output logic        risc_v_write,
  output logic [9:0]  risc_v_addr,
  output logic [31:0] risc_v_data_in,
  input  logic [15:0] risc_v_data_out,
  input  logic [15:0] spike_detected,
  input  logic        spike_clr,
  output logic [15:0] spike_sticky,
  output logic        spike_event,
  output logic [15:0] txn_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // The counter is loaded on the ISSUE->WAIT edge, so the first WAIT cycle
  // is strobe+1; reaching zero then lands exactly on strobe+READ_LATENCY.
  localparam logic [2:0] WAIT_LOAD = 3'(READ_LATENCY - 1);

  state_t     state;
  logic       lat_write;
  logic [2:0] wait_cnt;

  // Transaction FSM. All outputs are registered; risc_v_addr and
  // risc_v_data_in double as the latched command address and data.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      lat_write      <= 1'b0;
      wait_cnt       <= 3'd0;
      cmd_ready      <= 1'b1;
      rsp_valid      <= 1'b0;
      rsp_write      <= 1'b0;
      rsp_rdata      <= 16'h0000;
      risc_v_read    <= 1'b0;
      risc_v_write   <= 1'b0;
      risc_v_addr    <= 10'h000;
      risc_v_data_in <= 32'h0000_0000;
      txn_count      <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            lat_write      <= cmd_write;
            risc_v_addr    <= cmd_addr;
            risc_v_data_in <= cmd_wdata;
            risc_v_read    <= ~cmd_write;
            risc_v_write   <= cmd_write;
            cmd_ready      <= 1'b0;
            state          <= ISSUE;
          end
        end

        ISSUE: begin
          risc_v_read  <= 1'b0;
          risc_v_write <= 1'b0;
          if (lat_write) begin
            rsp_valid <= 1'b1;
            rsp_write <= 1'b1;
            rsp_rdata <= 16'h0000;
            state     <= RESP;
          end else begin
            wait_cnt <= WAIT_LOAD;
            state    <= WAIT;
          end
        end

        WAIT: begin
          if (wait_cnt == 3'd0) begin
            rsp_valid <= 1'b1;
            rsp_write <= 1'b0;
            rsp_rdata <= risc_v_data_out;
            state     <= RESP;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            txn_count <= txn_count + 16'd1;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

  // Spike accumulator. A bit that is set in the same cycle as spike_clr
  // survives the clear. The event compares against the pre-update sticky
  // value, so it fires only for bits not already accumulated.
  always_ff @(posedge clk) begin
    if (reset) begin
      spike_sticky <= 16'h0000;
      spike_event  <= 1'b0;
    end else begin
      spike_event  <= |(spike_detected & ~spike_sticky);
      spike_sticky <= (spike_clr ? 16'h0000 : spike_sticky) | spike_detected;
    end
  end

endmodule

// File: doc/soc_bus_master.md
SOC_BUS_MASTER -- requirements
Module: soc_bus_master

Interface
REQ-001 The module SHALL have parameter READ_LATENCY, default 1 (legal 1..7): cycles from the bus_read strobe cycle to the cycle bus_rdata is valid.
REQ-002 The module SHALL have one clock `clk` and one reset `reset`; reset SHALL be synchronous and active-high.
REQ-003 Ports SHALL be, one per line (name, direction, width, meaning):
  clk  in  1  clock
  reset  in  1  synchronous active-high reset
  cmd_valid  in  1  command offered
  cmd_ready  out  1  command accepted when high with cmd_valid
  cmd_write  in  1  1=write, 0=read
  cmd_addr  in  10  register address
  cmd_wdata  in  32  write data
  rsp_valid  out  1  response available
  rsp_ready  in  1  response consumed when high with rsp_valid
  rsp_write  out  1  echo of the command type
  rsp_rdata  out  16  read data (0 for writes)
  risc_v_read  out  1  single-cycle read strobe to SoC_Top
  risc_v_write  out  1  single-cycle write strobe to SoC_Top
  risc_v_addr  out  10  bus address
  risc_v_data_in  out  32  bus write data
  risc_v_data_out  in  16  bus read data from SoC_Top
  spike_detected  in  16  per-channel spike flags from SoC_Top
  spike_clr  in  1  clear sticky spike flags
  spike_sticky  out  16  accumulated spike flags
  spike_event  out  1  one-cycle pulse on any new spike bit
  txn_count  out  16  completed transactions

Function
REQ-004 The FSM SHALL have states IDLE, ISSUE, WAIT, RESP.
REQ-005 cmd_ready SHALL be 1 only in IDLE; at most one transaction is outstanding.
REQ-006 IDLE: on cmd_valid, the block SHALL latch cmd_write/cmd_addr/cmd_wdata and go to ISSUE.
REQ-007 ISSUE (exactly one cycle): risc_v_read=~write or risc_v_write=write SHALL be asserted, never both; risc_v_addr and risc_v_data_in SHALL show the latched values.
REQ-008 From ISSUE, a write SHALL go to RESP with rsp_rdata=0, and a read SHALL go to WAIT.
REQ-009 WAIT: a 3-bit counter loaded with READ_LATENCY-1 SHALL decrement each cycle. In the cycle it reads 0, risc_v_data_out SHALL be captured into rsp_rdata and the FSM SHALL go to RESP.
REQ-010 With the strobe in cycle T, rsp_valid SHALL rise in cycle T+1 for writes and T+READ_LATENCY+1 for reads.
REQ-011 RESP: rsp_valid, rsp_write and rsp_rdata SHALL hold stable until rsp_ready. On handshake, txn_count SHALL increment (wrapping 0xFFFF->0x0000) and the FSM SHALL return to IDLE.
REQ-012 A new command SHALL be acceptable in the cycle after a response handshake (back-to-back spacing: write 3 cycles, read READ_LATENCY+3 cycles minimum).
REQ-013 risc_v_addr and risc_v_data_in SHALL retain their last values between transactions; strobes SHALL be 0 outside ISSUE.
REQ-014 Spike flags SHALL update every cycle: spike_sticky <= (spike_clr ? 0 : spike_sticky) | spike_detected. A simultaneous set wins over clear.
REQ-015 spike_event SHALL pulse for one cycle, one cycle after any bit of spike_detected & ~spike_sticky is 1.
REQ-016 Spike logic SHALL be independent of the transaction FSM state.

Reset
REQ-017 On reset, the FSM SHALL go to IDLE and the outputs SHALL be: cmd_ready=1 (from the cycle after reset deasserts), rsp_valid=0, rsp_write=0, rsp_rdata=0, risc_v_read=0, risc_v_write=0, risc_v_addr=0, risc_v_data_in=0, spike_sticky=0, spike_event=0, txn_count=0.
REQ-018 Reset during ISSUE/WAIT/RESP SHALL abandon the transaction without a response and drop all strobes in the next cycle.
REQ-019 Commands presented while reset is high SHALL be ignored.

Verification
REQ-020 Write: cmd addr=0x004, wdata=0x12345678 -> risc_v_write=1 for exactly one cycle with addr 0x004 / data 0x12345678; rsp_valid next cycle with rsp_write=1, rsp_rdata=0; txn_count=1 after handshake.
REQ-021 Read, READ_LATENCY=3, bus returns 0xBEEF at strobe+3 -> rsp_rdata=0xBEEF, rsp_valid at strobe+4, risc_v_read high one cycle only.
REQ-022 Backpressure: hold rsp_ready=0 for 10 cycles -> rsp fields stable, cmd_ready=0, no new strobe, txn_count unchanged until handshake.
REQ-023 Back-to-back: four alternating write/read commands with cmd_valid held high -> four strobes in order, minimum spacing per REQ-012, txn_count=4.
REQ-024 Spikes: spike_detected=0x0005 one cycle, then 0x0004, then spike_clr with 0x0100 -> sticky 0x0005, single spike_event, then sticky=0x0100 with a second event.
REQ-025 Reset asserted in WAIT -> no rsp_valid, all outputs at reset values, next command completes normally.
